// File: rtl/core_pipe_stage.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush and optional skid entry.
// Control bits are forced to zero on the output whenever no valid beat is held.
module core_pipe_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 3,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        level
);

  typedef enum logic [1:0] {
    StEmpty,
    StFull,
    StSkidded
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] head_data_q, skid_data_q;
  logic [CTRL_W-1:0] head_ctrl_q, skid_ctrl_q;
  logic              valid_q;
  logic              rdy_q;
  logic [1:0]        level_q;

  logic accept, emit;
  logic load_head, head_from_skid, load_skid;

  assign in_ready  = (SKID != 0) ? rdy_q : (~valid_q | out_ready);
  assign accept    = in_valid & in_ready & ~flush;
  assign emit      = valid_q & out_ready;
  assign out_valid = valid_q;
  assign out_data  = head_data_q;
  assign out_ctrl  = valid_q ? head_ctrl_q : '0;
  assign level     = level_q;

  always_comb begin
    state_d        = state_q;
    load_head      = 1'b0;
    head_from_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d   = StFull;
          load_head = 1'b1;
        end
      end
      StFull: begin
        if (accept && emit) begin
          load_head = 1'b1;
        end else if (accept && (SKID != 0)) begin
          state_d   = StSkidded;
          load_skid = 1'b1;
        end else if (emit) begin
          state_d = StEmpty;
        end
      end
      StSkidded: begin
        if (emit) begin
          state_d        = StFull;
          head_from_skid = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
    // A beat emitted this cycle is still delivered; only what remains is discarded.
    if (flush) begin
      state_d        = StEmpty;
      load_head      = 1'b0;
      head_from_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      valid_q     <= 1'b0;
      rdy_q       <= 1'b1;
      level_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      if (load_head) begin
        head_data_q <= in_data;
        head_ctrl_q <= in_ctrl;
      end else if (head_from_skid) begin
        head_data_q <= skid_data_q;
        head_ctrl_q <= skid_ctrl_q;
      end
      if (load_skid) begin
        skid_data_q <= in_data;
        skid_ctrl_q <= in_ctrl;
      end
      valid_q <= (state_d != StEmpty);
      rdy_q   <= (state_d != StSkidded);
      level_q <= (state_d == StSkidded) ? 2'd2 : ((state_d == StFull) ? 2'd1 : 2'd0);
    end
  end

endmodule

// File: tb/tb_core_pipe_stage.sv
// Scoreboard bench for core_pipe_stage: one SKID=1 and one SKID=0 instance driven with directed
// vectors; monitors pop expected beats whenever a handshake completes on the output.
module tb_core_pipe_stage;
  localparam int DW = 64;
  localparam int CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          flush, iv, ir, ov, ordy;
  logic [DW-1:0] id, od;
  logic [CW-1:0] ic, oc;
  logic [1:0]    lvl;
  logic          flush0, iv0, ir0, ov0, ordy0;
  logic [DW-1:0] id0, od0;
  logic [CW-1:0] ic0, oc0;
  logic [1:0]    lvl0;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic [DW+CW-1:0] q1[$];
  logic [DW+CW-1:0] q0[$];
  logic [DW+CW-1:0] e1, e0;

  core_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv), .in_ready(ir), .in_data(id),
    .in_ctrl(ic), .out_valid(ov), .out_ready(ordy), .out_data(od), .out_ctrl(oc), .level(lvl)
  );

  core_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_single (
    .clk(clk), .rst(rst), .flush(flush0), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .in_ctrl(ic0), .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .out_ctrl(oc0),
    .level(lvl0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a beat on the skid instance and wait (bounded) until it is taken.
  task automatic send1(input logic [DW-1:0] d, input logic [CW-1:0] c);
    bit acc;
    acc = 1'b0;
    iv  = 1'b1;
    id  = d;
    ic  = c;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = ir;
      step();
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept want accept");
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ov && ordy) begin
        if (q1.size() == 0) begin
          total++;
          bad++;
          $display("FAIL skid_unexpected: got %h want none", od);
        end else begin
          e1 = q1.pop_front();
          chk("skid_data", od, e1[DW+CW-1:CW]);
          chk("skid_ctrl", 64'(oc), 64'(e1[CW-1:0]));
        end
      end else if (!ov) begin
        chk("skid_ctrl_gate", 64'(oc), 64'h0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (ov0 && ordy0) begin
        if (q0.size() == 0) begin
          total++;
          bad++;
          $display("FAIL single_unexpected: got %h want none", od0);
        end else begin
          e0 = q0.pop_front();
          chk("single_data", od0, e0[DW+CW-1:CW]);
          chk("single_ctrl", 64'(oc0), 64'(e0[CW-1:0]));
        end
      end else if (!ov0) begin
        chk("single_ctrl_gate", 64'(oc0), 64'h0);
      end
      chk("single_level_max", 64'(lvl0 > 2'd1), 64'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0; iv = 1'b1; id = 64'h99; ic = 3'b111; ordy = 1'b1;
    flush0 = 1'b0; iv0 = 1'b1; id0 = 64'h99; ic0 = 3'b111; ordy0 = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_ov", 64'(ov), 64'h0);
    chk("rst_oc", 64'(oc), 64'h0);
    chk("rst_lvl", 64'(lvl), 64'h0);
    chk("rst_ov0", 64'(ov0), 64'h0);
    chk("rst_lvl0", 64'(lvl0), 64'h0);
    step();
    rst = 1'b0; iv = 1'b0; iv0 = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_ir", 64'(ir), 64'h1);
    step();

    // Streaming through the skid instance.
    ordy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      iv = 1'b1; id = 64'h10 + 64'(i); ic = 3'b101;
      q1.push_back({id, ic});
      @(negedge clk);
      chk("stream_ir", 64'(ir), 64'h1);
      if (i > 0) begin
        chk("stream_lvl", 64'(lvl), 64'h1);
        chk("stream_ov", 64'(ov), 64'h1);
      end
      step();
    end
    iv = 1'b0;
    @(negedge clk);
    chk("stream_last_lvl", 64'(lvl), 64'h1);
    step();
    @(negedge clk);
    chk("stream_empty_lvl", 64'(lvl), 64'h0);
    step();

    // Back-pressure on the skid instance.
    ordy = 1'b0;
    q1.push_back({64'hA, 3'b011});
    q1.push_back({64'hB, 3'b011});
    q1.push_back({64'hC, 3'b011});
    iv = 1'b1; id = 64'hA; ic = 3'b011;
    @(negedge clk);
    chk("bp_ir_a", 64'(ir), 64'h1);
    chk("bp_lvl_a", 64'(lvl), 64'h0);
    step();
    id = 64'hB;
    @(negedge clk);
    chk("bp_lvl_b", 64'(lvl), 64'h1);
    chk("bp_ir_b", 64'(ir), 64'h1);
    step();
    id = 64'hC;
    @(negedge clk);
    chk("bp_lvl_2", 64'(lvl), 64'h2);
    chk("bp_ir_full", 64'(ir), 64'h0);
    chk("bp_head", od, 64'hA);
    step();
    @(negedge clk);
    chk("bp_hold_lvl", 64'(lvl), 64'h2);
    chk("bp_hold_ir", 64'(ir), 64'h0);
    step();
    ordy = 1'b1;
    @(negedge clk);
    chk("bp_release_ir", 64'(ir), 64'h0);
    step();
    @(negedge clk);
    chk("bp_refill_ir", 64'(ir), 64'h1);
    chk("bp_refill_lvl", 64'(lvl), 64'h1);
    step();
    iv = 1'b0;
    @(negedge clk);
    chk("bp_tail_lvl", 64'(lvl), 64'h1);
    step();
    @(negedge clk);
    chk("bp_done_lvl", 64'(lvl), 64'h0);
    step();

    // Flush while SKIDDED, with a beat offered in the same cycle.
    ordy = 1'b0;
    send1(64'h21, 3'b001);
    send1(64'h22, 3'b001);
    id = 64'h55; ic = 3'b111; flush = 1'b1;
    @(negedge clk);
    chk("fl_pre_lvl", 64'(lvl), 64'h2);
    step();
    flush = 1'b0; iv = 1'b0;
    @(negedge clk);
    chk("fl_lvl", 64'(lvl), 64'h0);
    chk("fl_ov", 64'(ov), 64'h0);
    chk("fl_oc", 64'(oc), 64'h0);
    ordy = 1'b1;
    step();
    repeat (3) step();
    // Flush from empty drops the beat even though in_ready is high.
    iv = 1'b1; id = 64'h56; flush = 1'b1;
    @(negedge clk);
    chk("fl_empty_ir", 64'(ir), 64'h1);
    step();
    flush = 1'b0; iv = 1'b0;
    @(negedge clk);
    chk("fl_empty_ov", 64'(ov), 64'h0);
    chk("fl_empty_lvl", 64'(lvl), 64'h0);
    step();

    // Flush together with an emit: the head beat is still delivered.
    ordy = 1'b1;
    iv = 1'b1; id = 64'h31; ic = 3'b110;
    q1.push_back({id, ic});
    step();
    id = 64'h32; flush = 1'b1;
    @(negedge clk);
    chk("fe_ov", 64'(ov), 64'h1);
    step();
    flush = 1'b0; iv = 1'b0;
    @(negedge clk);
    chk("fe_lvl", 64'(lvl), 64'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      iv = 1'b1; id = 64'h40 + 64'(i); ic = 3'b010;
      q1.push_back({id, ic});
      @(negedge clk);
      chk("fe_stream_ir", 64'(ir), 64'h1);
      if (i > 0) chk("fe_stream_lvl", 64'(lvl), 64'h1);
      step();
    end
    iv = 1'b0;
    repeat (3) step();
    chk("skid_drained", 64'(q1.size()), 64'h0);

    // Single-entry instance: streaming, then combinational back-pressure.
    ordy0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iv0 = 1'b1; id0 = (i < 4) ? 64'h60 + 64'(i) : 64'h77; ic0 = 3'b100;
      q0.push_back({id0, ic0});
      @(negedge clk);
      chk("s0_stream_ir", 64'(ir0), 64'h1);
      if (i > 0) chk("s0_stream_lvl", 64'(lvl0), 64'h1);
      step();
    end
    ordy0 = 1'b0; id0 = 64'h78; ic0 = 3'b100;
    q0.push_back({id0, ic0});
    #1;
    chk("s0_bp_ir", 64'(ir0), 64'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("s0_hold_data", od0, 64'h77);
      chk("s0_hold_lvl", 64'(lvl0), 64'h1);
      chk("s0_hold_ir", 64'(ir0), 64'h0);
      step();
    end
    ordy0 = 1'b1;
    #1;
    chk("s0_release_ir", 64'(ir0), 64'h1);
    step();
    iv0 = 1'b0;
    @(negedge clk);
    chk("s0_tail_lvl", 64'(lvl0), 64'h1);
    step();
    @(negedge clk);
    chk("s0_empty_lvl", 64'(lvl0), 64'h0);
    step();
    chk("single_drained", 64'(q0.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
